// File: rtl/trace_pkg.sv
// Shared constants and helpers for the execution-trace capture unit.
// Record layout is {timestamp, pc, watch snapshot}, MSB first.
package trace_pkg;

  localparam logic TRACE_ALWAYS    = 1'b0;
  localparam logic TRACE_ON_CHANGE = 1'b1;
  localparam int   DROP_W          = 16;

  function automatic int rec_width(
    input int ts_w,
    input int pc_w,
    input int num_ch,
    input int data_w
  );
    return ts_w + pc_w + num_ch * data_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word (first-word fall-through).
// Full/empty come from one extra pointer bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_nxt;
  logic [AW:0]      w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) &&
                 (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign dout  = r_head;

  assign w_pop    = pop & ~empty;
  assign w_push   = push & (~full | w_pop);
  assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};
  assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_push};

  // Head is whatever will sit at the read pointer after this edge.
  always_comb begin
    w_head_nxt = r_head;
    if (w_rd_nxt != w_wr_nxt) begin
      if (w_push && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0]))
        w_head_nxt = din;
      else
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_rd   <= w_rd_nxt;
      r_head <= w_head_nxt;
    end
  end

endmodule

// File: rtl/trace_capture_unit.sv
// Timestamped trace capture: change detection, cycle budget and
// drop accounting in front of a fall-through record FIFO.
module trace_capture_unit
  import trace_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PC_W-1:0]                            pc,
  input  logic [NUM_CH*DATA_W-1:0]                   watch,
  input  logic [NUM_CH-1:0]                          ch_en,
  input  logic                                       mode,
  input  logic [TS_W-1:0]                            stop_cycles,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [rec_width(TS_W,PC_W,NUM_CH,DATA_W)-1:0] out_data,
  output logic                                       overflow,
  output logic [DROP_W-1:0]                          drop_cnt,
  output logic                                       done
);

  localparam int RW = rec_width(TS_W, PC_W, NUM_CH, DATA_W);

  logic [TS_W-1:0]          r_ts;
  logic [NUM_CH*DATA_W-1:0] r_prev;
  logic                     r_base_vld;
  logic                     r_overflow;
  logic [DROP_W-1:0]        r_drop_cnt;
  logic                     r_done;

  logic                     w_chg;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_last;
  logic                     w_full;
  logic                     w_empty;
  logic [RW-1:0]            w_rec;

  always_comb begin
    w_chg = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i] &&
          (watch[i*DATA_W +: DATA_W] != r_prev[i*DATA_W +: DATA_W]))
        w_chg = 1'b1;
    end
  end

  assign w_push = ~r_done &
                  ((mode == TRACE_ALWAYS) | ~r_base_vld | w_chg);
  // Full FIFO only drops when the consumer is not taking the head.
  assign w_drop = w_push & w_full & ~out_ready;
  assign w_last = (stop_cycles != '0) &&
                  (r_ts == stop_cycles - {{(TS_W-1){1'b0}}, 1'b1});
  assign w_rec  = {r_ts, pc, watch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts       <= '0;
      r_prev     <= '0;
      r_base_vld <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_push) begin
        r_prev     <= watch;
        r_base_vld <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1)
          r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (!r_done) begin
        r_ts <= r_ts + 1'b1;
        if (w_last)
          r_done <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_rec),
    .full  (w_full),
    .pop   (out_ready),
    .empty (w_empty),
    .dout  (out_data)
  );

  assign out_valid = ~w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit: queue-based record model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_trace_capture_unit;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
  localparam int WW     = NUM_CH * DATA_W;
  localparam int RW     = TS_W + PC_W + WW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC_W-1:0]   pc = '0;
  logic [WW-1:0]     watch = '0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              mode = 1'b0;
  logic [TS_W-1:0]   stop_cycles = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RW-1:0]     out_data;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              done;

  trace_capture_unit #(
    .NUM_CH (NUM_CH), .DATA_W (DATA_W), .PC_W (PC_W),
    .TS_W (TS_W), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst), .pc (pc), .watch (watch),
    .ch_en (ch_en), .mode (mode), .stop_cycles (stop_cycles),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .overflow (overflow),
    .drop_cnt (drop_cnt), .done (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: what has been captured, as a plain queue.
  logic [RW-1:0] q[$];
  logic [RW-1:0] popped[$];
  int            m_ts;
  bit            m_done;
  bit            m_base;
  logic [WW-1:0] m_prev;
  bit            m_ovf;
  int            m_drop;

  function automatic int rec_ts(input logic [RW-1:0] r);
    return int'(r[RW-1 -: TS_W]);
  endfunction

  function automatic int rec_pc(input logic [RW-1:0] r);
    return int'(r[RW-TS_W-1 -: PC_W]);
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] got,
                      input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_done = 0; m_base = 0;
    m_prev = '0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic compare();
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chkw("out_data", out_data, q[0]);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("done", done, m_done);
  endtask

  // Advance the model by one edge using current inputs, then compare.
  task automatic tick();
    bit pop, push, chg, full;
    full = (q.size() == DEPTH);
    pop  = out_ready && (q.size() > 0);
    push = 0;
    if (!m_done) begin
      chg = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (ch_en[i] && watch[i*DATA_W +: DATA_W] != m_prev[i*DATA_W +: DATA_W])
          chg = 1;
      push = (mode == 1'b0) || !m_base || chg;
    end
    if (pop) popped.push_back(q.pop_front());
    if (push) begin
      if (full && !pop) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end else begin
        q.push_back({m_ts[TS_W-1:0], pc, watch});
      end
      m_prev = watch;
      m_base = 1;
    end
    if (!m_done) begin
      if (stop_cycles != 0 && m_ts == int'(stop_cycles) - 1) m_done = 1;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    popped.delete();
  endtask

  function automatic logic [WW-1:0] rand_watch();
    logic [WW-1:0] w;
    for (int i = 0; i < NUM_CH; i++) w[i*DATA_W +: DATA_W] = $urandom;
    return w;
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chkw("reset out_data", out_data, '0);
    chk("reset overflow", overflow, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    popped.delete();

    // ALWAYS mode, pc stepping by 4.
    mode = 1'b0; out_ready = 1'b1; stop_cycles = '0; ch_en = '1;
    for (int k = 0; k < 8; k++) begin
      pc = PC_W'(4 * k);
      watch = rand_watch();
      tick();
    end
    chk("s1 popped", popped.size(), 7);
    chk("s1 ts0", rec_ts(popped[0]), 0);
    chk("s1 pc0", rec_pc(popped[0]), 0);
    chk("s1 ts2", rec_ts(popped[2]), 2);
    chk("s1 pc2", rec_pc(popped[2]), 8);

    // ON_CHANGE with only channel 0 enabled.
    do_reset();
    mode = 1'b1; ch_en = 8'h01; out_ready = 1'b1;
    watch = rand_watch();
    for (int t = 0; t < 14; t++) begin
      if (t == 5 || t == 9) watch[0 +: DATA_W] = watch[0 +: DATA_W] + 1;
      if (t == 7) watch[3*DATA_W +: DATA_W] = ~watch[3*DATA_W +: DATA_W];
      pc = PC_W'(t);
      tick();
    end
    chk("s2 count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("s2 ts0", rec_ts(popped[0]), 0);
      chk("s2 ts1", rec_ts(popped[1]), 5);
      chk("s2 ts2", rec_ts(popped[2]), 9);
    end

    // Stalled consumer: fill, overflow, then drain.
    do_reset();
    mode = 1'b0; out_ready = 1'b0; ch_en = '0;
    for (int k = 0; k < 36; k++) begin
      pc = $urandom; watch = rand_watch();
      tick();
    end
    chk("s3 overflow", overflow, 1);
    chk("s3 drop_cnt", drop_cnt, 20);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pc = $urandom; watch = rand_watch();
      tick();
    end
    for (int k = 0; k < 16; k++) chk("s3 drain ts", rec_ts(popped[k]), k);

    // Full FIFO with continuous pops keeps occupancy, no drops.
    do_reset();
    mode = 1'b0; out_ready = 1'b0;
    repeat (16) tick();
    chk("s5 full size", q.size(), 16);
    out_ready = 1'b1;
    repeat (10) begin
      pc = $urandom; tick();
    end
    chk("s5 drop_cnt", drop_cnt, 0);
    chk("s5 occupancy", q.size(), 16);

    // Cycle budget of 10.
    do_reset();
    mode = 1'b0; out_ready = 1'b1; stop_cycles = 16'd10;
    for (int k = 0; k < 20; k++) begin
      pc = PC_W'(k); tick();
    end
    chk("s4 done", done, 1);
    chk("s4 count", popped.size(), 10);
    chk("s4 last ts", rec_ts(popped[popped.size()-1]), 9);
    chk("s4 model ts", m_ts, 10);
    stop_cycles = '0;

    // Reset mid-run with five records buffered.
    do_reset();
    mode = 1'b0; out_ready = 1'b0;
    repeat (5) tick();
    chk("s6 buffered", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("s6 async valid", out_valid, 0);
    chk("s6 async drop", drop_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    popped.delete();
    out_ready = 1'b1;
    repeat (2) tick();
    chk("s6 first ts", rec_ts(popped[0]), 0);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k % 150 == 0) begin
        mode = 1'($urandom);
        ch_en = NUM_CH'($urandom);
        stop_cycles = ($urandom_range(0, 3) == 0) ?
                      TS_W'($urandom_range(20, 120)) : '0;
      end
      if (k % 150 == 149) do_reset();
      pc = $urandom;
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 7) == 0) watch[i*DATA_W +: DATA_W] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
